mem32_byte_streamer: RTL

Downstream read sequencer for the 4-byte `mem32` store. On a `start` pulse it issues four single-cycle reads (addr 0..3) to the store, captures each returned byte, and presents the bytes on a valid/ready byte stream, least-significant byte first. An optional XOR checksum byte can be appended. It feeds byte-wide consumers such as a serializer or a host FIFO.

---
 rtl/mem32_byte_streamer.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem32_byte_streamer.sv
// mem32_byte_streamer
//
// Reads the four bytes of the mem32 store (addr 0..3) one at a time on a
// start pulse and presents them LSB first on a valid/ready byte stream.
// Optionally appends an XOR checksum byte.
//
// Build option:
//   STREAM_CSUM_EN  when defined, a fifth byte (XOR of the four data bytes)
//                   follows the data and carries m_last. When undefined,
//                   byte 3 carries m_last and the stream is four bytes.
//
// Parameters:
//   TIMEOUT    cycles to wait for mem_valid after a read request (1..255)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a 4-byte transfer (sampled only while idle)
//   busy       high whenever not idle
//   done       one-cycle pulse at the end of a transfer (ok or errored)
//   err        sticky timeout flag, cleared by the next accepted start
//   mem_rd     read strobe to the store
//   mem_wr     write strobe to the store, always 0
//   mem_addr   byte address of the current read
//   mem_data   store read data
//   mem_valid  store read data valid
//   m_data     stream byte
//   m_valid    stream valid
//   m_ready    stream ready from the consumer
//   m_last     final byte of the transfer
//
// All outputs decode from registered state only; there is no combinational
// path from m_ready or mem_valid to any output.

module mem32_byte_streamer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [1:0] mem_addr,
    input  logic [7:0] mem_data,
    input  logic       mem_valid,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last
);

    localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

`ifdef STREAM_CSUM_EN
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StSend,
        StCsum,
        StDone
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StSend,
        StDone
    } state_e;
`endif

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] byte_q, byte_d;
    logic       err_q, err_d;
    logic [7:0] timer_inc;
`ifdef STREAM_CSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            timer_q <= 8'd0;
            byte_q  <= 8'd0;
            err_q   <= 1'b0;
`ifdef STREAM_CSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
`ifdef STREAM_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign timer_inc = timer_q + 8'd1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        byte_d  = byte_q;
        err_d   = err_q;
`ifdef STREAM_CSUM_EN
        csum_d  = csum_q;
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = 2'd0;
                    err_d   = 1'b0;
`ifdef STREAM_CSUM_EN
                    csum_d  = 8'd0;
`endif
                    state_d = StReq;
                end
            end

            StReq: begin
                timer_d = 8'd0;
                state_d = StWait;
            end

            StWait: begin
                if (mem_valid) begin
                    byte_d  = mem_data;
`ifdef STREAM_CSUM_EN
                    csum_d  = csum_q ^ mem_data;
`endif
                    state_d = StSend;
                end else if (timer_inc >= TimeoutVal) begin
                    // Saturate at TIMEOUT; the transfer ends with no more bytes.
                    timer_d = TimeoutVal;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    timer_d = timer_inc;
                end
            end

            StSend: begin
                // m_valid is high throughout SEND, so m_ready alone completes it.
                if (m_ready) begin
                    if (idx_q == 2'd3) begin
`ifdef STREAM_CSUM_EN
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = StReq;
                    end
                end
            end

`ifdef STREAM_CSUM_EN
            StCsum: begin
                if (m_ready) begin
                    state_d = StDone;
                end
            end
`endif

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = 2'd0;
        m_data   = 8'd0;
        m_valid  = 1'b0;
        m_last   = 1'b0;

        case (state_q)
            StIdle: begin
                busy = 1'b0;
            end

            StReq: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = idx_q;
            end

            StWait: begin
                busy = 1'b1;
            end

            StSend: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_data  = byte_q;
`ifdef STREAM_CSUM_EN
                m_last  = 1'b0;
`else
                m_last  = (idx_q == 2'd3);
`endif
            end

`ifdef STREAM_CSUM_EN
            StCsum: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_data  = csum_q;
                m_last  = 1'b1;
            end
`endif

            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end

            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign err    = err_q;
    assign mem_wr = 1'b0;

endmodule
